// File: rtl/sr_lut_accum9_if.sv
// Input beat stream and output sum stream of the SR-LUT accumulate stage.
// The slave modport is the accumulator; the master modport is the producer/divider side.
interface sr_lut_accum9_if #(
  parameter int LANES = 4,
  parameter int IN_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*IN_W-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*32-1:0]   out_data;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sr_lut_accum9.sv
// Per-lane sum over TAPS beats into a one-entry output buffer; result valid the cycle after the closing beat.
// Only a closing beat can stall (buffer full, not draining). ACC9_PERF_EN adds perf_groups/perf_stall.
module sr_lut_accum9 #(
  parameter int LANES = 4,
  parameter int IN_W  = 8,
  parameter int TAPS  = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  sr_lut_accum9_if.slave      bus,
`ifdef ACC9_PERF_EN
  output logic [31:0]         perf_groups,
  output logic [31:0]         perf_stall,
`endif
  output logic                err
);
  localparam int CW = (TAPS <= 2) ? 1 : $clog2(TAPS);

  logic [CW-1:0]             cnt;
  logic [LANES-1:0][31:0]    acc;
  logic [LANES-1:0][31:0]    sum;
  logic [LANES-1:0][31:0]    out_q;
  logic                      out_vld_q;
  logic [IN_W-1:0]           lane;
  logic                      closing;
  logic                      rdy;
  logic                      take;
  logic                      drain;

  assign closing = (cnt == CW'(TAPS - 1));
  assign rdy     = !(closing && out_vld_q && !bus.out_ready);
  assign take    = bus.in_valid && rdy;
  assign drain   = out_vld_q && bus.out_ready;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_q;

  // First beat of a group reloads; the closing beat's sum goes straight to the output buffer.
  always_comb begin
    sum  = '0;
    lane = '0;
    for (int k = 0; k < LANES; k++) begin
      lane   = bus.in_data[k*IN_W +: IN_W];
      sum[k] = ((cnt == '0) ? 32'd0 : acc[k]) + {{(32-IN_W){lane[IN_W-1]}}, lane};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      err <= 1'b0;
    end else if (take) begin
      cnt <= closing ? '0 : cnt + CW'(1);
      acc <= sum;
      // in_last is only checked; the counter alone decides where groups end
      if (bus.in_last != closing)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (take && closing) begin
      out_q     <= sum;
      out_vld_q <= 1'b1;
    end else if (drain) begin
      out_vld_q <= 1'b0;
    end
  end

`ifdef ACC9_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_groups <= '0;
      perf_stall  <= '0;
    end else begin
      if (drain)
        perf_groups <= perf_groups + 32'd1;
      if (bus.in_valid && !rdy)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule
